// File: rtl/reg_file_flags_pkg.sv
// Shared register-file definitions: architectural sizes, the hardwired zero
// index and status-flag bit positions, also used by the ALU and control stages.
package reg_file_flags_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;

    // Single place that fixes the {carry, overflow, zero} ordering.
    function automatic logic [2:0] pack_flags(input logic c, input logic v, input logic z);
        logic [2:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/reg_file_flags_reg_32.sv
// One general-purpose register: DATA_W bits, synchronous active-high clear,
// load enable. One instance per writable register index.
module reg_32
    import reg_file_flags_pkg::*;
#(
    parameter int DATA_W = reg_file_flags_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_flags.sv
// 32 x 32-bit register file with two asynchronous read ports, one synchronous
// write port and a 3-bit ALU status register. Define REG_FILE_BYPASS_EN to
// forward write-back data to a read port that addresses the register being written.
module reg_file_flags
#(
    parameter int DATA_W   = reg_file_flags_pkg::DATA_W,
    parameter int NUM_REGS = reg_file_flags_pkg::NUM_REGS,
    parameter int ADDR_W   = reg_file_flags_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] rw_addr,
    input  logic [DATA_W-1:0] bus_w,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] bus_a,
    output logic [DATA_W-1:0] bus_b,
    input  logic              flag_we,
    input  logic              carry_in,
    input  logic              overflow_in,
    input  logic              zero_in,
    output logic [2:0]        flags
);
    import reg_file_flags_pkg::*;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Index 0 has no storage; it reads as a constant zero.
    assign regs[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic load;
        assign load = we & (rw_addr == ADDR_W'(i));

        reg_32 #(
            .DATA_W(DATA_W)
        ) u_reg (
            .clk  (clk),
            .rst  (rst),
            .load (load),
            .d    (bus_w),
            .q    (regs[i])
        );
    end

`ifdef REG_FILE_BYPASS_EN
    logic wr_live;
    logic fwd_a;
    logic fwd_b;

    // Forwarding is gated off during reset so the ports show stored contents.
    assign wr_live = we & ~rst & (rw_addr != REG_ZERO);
    assign fwd_a   = wr_live & (rw_addr == ra_addr);
    assign fwd_b   = wr_live & (rw_addr == rb_addr);

    assign bus_a = fwd_a ? bus_w : regs[ra_addr];
    assign bus_b = fwd_b ? bus_w : regs[rb_addr];
`else
    assign bus_a = regs[ra_addr];
    assign bus_b = regs[rb_addr];
`endif

    // Status capture is independent of the register write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else if (flag_we) begin
            flags <= pack_flags(carry_in, overflow_in, zero_in);
        end
    end

endmodule

// File: doc/reg_file_flags.md
Name: reg_file_flags

Overview:
- Register-file stage directly upstream of the ALU in the single-cycle datapath.
- Holds 32 x 32-bit general registers and drives the ALU A/B operand buses through two asynchronous read ports.
- Accepts one synchronous write-back per cycle.
- Also captures the ALU carry/overflow/zero outputs into a 3-bit status register for later branch and condition use.

Parameters:
- DATA_W, 32, register and bus width in bits
- NUM_REGS, 32, number of architectural registers
- ADDR_W, 5, register address width; must equal clog2(NUM_REGS)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- we  input  1  register write enable
- rw_addr  input  ADDR_W  write register index
- bus_w  input  DATA_W  write-back data
- ra_addr  input  ADDR_W  read port A index
- rb_addr  input  ADDR_W  read port B index
- bus_a  output  DATA_W  port A data, feeds ALU A
- bus_b  output  DATA_W  port B data, feeds ALU B
- flag_we  input  1  status-register capture enable
- carry_in  input  1  ALU carry_out_flag
- overflow_in  input  1  ALU overflow
- zero_in  input  1  ALU zero_flag
- flags  output  3  registered status {carry, overflow, zero}

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Nothing changes state except on the rising edge of clk.
- Reset:
  - rst=1 at a rising edge clears every register and flags to 0. we and flag_we are ignored that cycle.
  - After reset, bus_a = bus_b = 0 for all addresses and flags = 3'b000.
  - Reset asserted in the same cycle as a write: reset wins and the write is lost.
- Write:
  - On a rising edge with rst=0 and we=1, reg[rw_addr] <= bus_w.
  - rw_addr=0: no effect. Register 0 is hardwired to zero and is never stored.
  - One write per cycle; no write occurs when we=0.
- Read:
  - bus_a = reg[ra_addr] and bus_b = reg[rb_addr], purely combinational with zero cycle latency.
  - Address 0 always returns 0.
  - Both ports may read the same address simultaneously and return identical data.
  - Read-during-write to the same index (default, no bypass): the port returns the OLD value until the edge and the new value after it.
- Status register:
  - On a rising edge with rst=0 and flag_we=1: flags <= {carry_in, overflow_in, zero_in}.
  - flag_we=0: flags hold their value.
  - Flags are independent of we. Both may be asserted in the same cycle, and both updates take effect.
- Widths: no arithmetic is performed. bus_w is stored unmodified with no sign or zero extension.
- Out-of-range address: not possible, since NUM_REGS = 2^ADDR_W.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN
- Defined: write-through forwarding.
  - If we=1, rst=0, rw_addr!=0 and rw_addr==ra_addr, then bus_a = bus_w combinationally in the write cycle. bus_b is forwarded under the same rule against rb_addr.
  - Address 0 is never forwarded.
  - During rst=1, forwarding is suppressed and the ports show stored contents.
- Undefined: no forwarding. Read-during-write returns the old value, as described under Behaviour.

Decomposition:
- Shared package:
  - constants DATA_W=32, NUM_REGS=32, ADDR_W=5
  - REG_ZERO=5'd0
  - flag bit indices FLAG_C=2, FLAG_V=1, FLAG_Z=0
  - typedef for a register address and a data word
  - The ALU and control stages use the same package.
- Sub-module: reg_32, a DATA_W-bit register with synchronous active-high reset and a load enable.
  - Instantiated once per register 1..31 via a generate loop.
  - Per-register enable = we & (rw_addr==i).
  - Read muxing and the flag register stay in the top level.

Test Plan:
- Reset:
  - Stimulus: fill r1..r31 with nonzero values, pulse rst=1 for one cycle.
  - Required: every read returns 0x00000000 and flags=3'b000.
- x0 protection:
  - Stimulus: we=1, rw_addr=0, bus_w=0xDEADBEEF, then ra_addr=0.
  - Required: bus_a=0x00000000.
- Write/dual read:
  - Stimulus: write r5=0x12345678 and r31=0xFFFFFFFF.
  - Required: ra=5, rb=31 gives bus_a=0x12345678, bus_b=0xFFFFFFFF; ra=rb=5 gives both 0x12345678.
- Read-during-write:
  - Stimulus: r7=0x1, then we=1, rw_addr=7, bus_w=0x2, ra_addr=7.
  - Required, bypass off: bus_a=0x1 before the edge and 0x2 after.
  - Required, REG_FILE_BYPASS_EN defined: bus_a=0x2 before the edge.
- Flags:
  - Stimulus: flag_we=1 with {1,0,1}, then flag_we=0 with {0,1,0}.
  - Required: flags=3'b101 after the first edge and still 3'b101 after the second.
- Reset mid-write:
  - Stimulus: rst=1 and we=1, rw_addr=3, bus_w=0xAA in the same cycle.
  - Required: r3 reads 0x00000000 afterwards.
